alu_cdb_unit: RTL and testbench

- Execution stage directly downstream of the reservation station.
- Accepts one ready-operand instruction per cycle and computes the integer, LUI/AUIPC, jump and branch result.
- Buffers results in a small in-order queue and broadcasts them on the common data bus (CDB) when the CDB arbiter grants the slot.
- Applies backpressure to the reservation station through alu_full.

---
 rtl/alu_cdb_unit_if.sv | 36 +++
 rtl/alu_cdb_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_cdb_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cdb_unit_if.sv
// Issue/broadcast bundle between reservation station, ALU and CDB arbiter.
// master = RS/arbiter side, slave = ALU side.
interface alu_cdb_unit_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
);
    logic              rs_to_alu_ready;
    logic [OP_W-1:0]   rs_to_alu_op;
    logic [DATA_W-1:0] rs_to_alu_rs1;
    logic [DATA_W-1:0] rs_to_alu_rs2;
    logic [ROB_W-1:0]  rs_to_alu_rob_index;
    logic [DATA_W-1:0] rs_to_alu_PC;
    logic [DATA_W-1:0] rs_to_alu_imm;
    logic              alu_full;
    logic              cdb_grant_in;
    logic              alu_to_rs_ready;
    logic [DATA_W-1:0] alu_to_rs_result;
    logic [ROB_W-1:0]  alu_to_rs_rob_index;
    logic              alu_to_rob_jump;
    logic [DATA_W-1:0] alu_to_rob_target;

    modport master (
        output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm, cdb_grant_in,
        input  alu_full, alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
               alu_to_rob_jump, alu_to_rob_target
    );

    modport slave (
        input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm, cdb_grant_in,
        output alu_full, alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
               alu_to_rob_jump, alu_to_rob_target
    );
endinterface

// File: rtl/alu_cdb_unit.sv
// Integer/jump/branch execute stage: result computed combinationally, pushed into an in-order
// queue at issue; head broadcast on the CDB, popped on grant. alu_full blocks issue when the queue is full.
module alu_cdb_unit #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int QDEPTH = 2
) (
    input logic           clk_in,
    input logic           rst_in,
    input logic           rdy_in,
    input logic           clr_in,
    alu_cdb_unit_if.slave bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(12);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(20);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(28);

    logic [DATA_W-1:0] res_q [QDEPTH];
    logic [ROB_W-1:0]  rob_q [QDEPTH];
    logic              jmp_q [QDEPTH];
    logic [DATA_W-1:0] tgt_q [QDEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] rs1, rs2, opb, pc4, jalr_sum, res_d, tgt_d;
    logic [4:0]        shamt;
    logic              jmp_d, take, push, pop, full, flush;

    assign rs1      = bus.rs_to_alu_rs1;
    assign rs2      = bus.rs_to_alu_rs2;
    assign opb      = (bus.rs_to_alu_op <= OP_AND) ? rs2 : bus.rs_to_alu_imm;
    assign shamt    = opb[4:0];
    assign pc4      = bus.rs_to_alu_PC + DATA_W'(4);
    assign jalr_sum = rs1 + bus.rs_to_alu_imm;

    always_comb begin
        res_d = '0;
        jmp_d = 1'b0;
        tgt_d = pc4;
        take  = 1'b0;
        case (bus.rs_to_alu_op)
            OP_ADD, OP_ADDI:   res_d = rs1 + opb;
            OP_SUB:            res_d = rs1 - opb;
            OP_SLL, OP_SLLI:   res_d = rs1 << shamt;
            OP_SLT, OP_SLTI:   res_d[0] = $signed(rs1) < $signed(opb);
            OP_SLTU, OP_SLTIU: res_d[0] = rs1 < opb;
            OP_XOR, OP_XORI:   res_d = rs1 ^ opb;
            OP_SRL, OP_SRLI:   res_d = rs1 >> shamt;
            OP_SRA, OP_SRAI:   res_d = $unsigned($signed(rs1) >>> shamt);
            OP_OR, OP_ORI:     res_d = rs1 | opb;
            OP_AND, OP_ANDI:   res_d = rs1 & opb;
            OP_LUI:            res_d = bus.rs_to_alu_imm;
            OP_AUIPC:          res_d = bus.rs_to_alu_PC + bus.rs_to_alu_imm;
            OP_JAL: begin
                res_d = pc4;
                jmp_d = 1'b1;
                tgt_d = bus.rs_to_alu_PC + bus.rs_to_alu_imm;
            end
            OP_JALR: begin
                res_d = pc4;
                jmp_d = 1'b1;
                tgt_d = {jalr_sum[DATA_W-1:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (bus.rs_to_alu_op)
                    OP_BEQ:  take = rs1 == rs2;
                    OP_BNE:  take = rs1 != rs2;
                    OP_BLT:  take = $signed(rs1) < $signed(rs2);
                    OP_BGE:  take = $signed(rs1) >= $signed(rs2);
                    OP_BLTU: take = rs1 < rs2;
                    default: take = rs1 >= rs2;
                endcase
                jmp_d = take;
                tgt_d = take ? (bus.rs_to_alu_PC + bus.rs_to_alu_imm) : pc4;
            end
            default: ;
        endcase
    end

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot for the push.
    assign full  = (cnt_q == CNT_W'(QDEPTH));
    assign flush = rst_in | clr_in;
    assign push  = rdy_in & bus.rs_to_alu_ready & ~full;
    assign pop   = rdy_in & bus.cdb_grant_in & (cnt_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        head_q <= head_d;
        tail_q <= tail_d;
        cnt_q  <= cnt_d;
    end

    always_ff @(posedge clk_in) begin
        if (flush) begin
            for (int i = 0; i < QDEPTH; i++) begin
                res_q[i] <= '0;
                rob_q[i] <= '0;
                jmp_q[i] <= 1'b0;
                tgt_q[i] <= '0;
            end
        end else if (push) begin
            res_q[tail_q] <= res_d;
            rob_q[tail_q] <= bus.rs_to_alu_rob_index;
            jmp_q[tail_q] <= jmp_d;
            tgt_q[tail_q] <= tgt_d;
        end
    end

    assign bus.alu_full            = full;
    assign bus.alu_to_rs_ready     = (cnt_q != '0);
    assign bus.alu_to_rs_result    = res_q[head_q];
    assign bus.alu_to_rs_rob_index = rob_q[head_q];
    assign bus.alu_to_rob_jump     = jmp_q[head_q];
    assign bus.alu_to_rob_target   = tgt_q[head_q];
endmodule

// File: tb/tb_alu_cdb_unit.sv
// Directed bench for alu_cdb_unit: opcode results, queue ordering, backpressure, flush and hold.
module tb_alu_cdb_unit;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int OP_W   = 6;
    localparam int QDEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   proto_err = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, imm, pc, res, tgt;
        logic        jmp;
    } vec_t;

    alu_cdb_unit_if #(.DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W)) bus ();

    alu_cdb_unit #(.DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .QDEPTH(QDEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clr_in (clr),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // An RS issue while the unit reports full is a protocol violation; a flush edge discards it anyway.
    always @(posedge clk) begin
        if (rdy && !clr && !rst && bus.rs_to_alu_ready && bus.alu_full) begin
            proto_err++;
            $display("protocol error: issue rob=%0d dropped while alu_full", bus.rs_to_alu_rob_index);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        bus.rs_to_alu_ready     = 1'b1;
        bus.rs_to_alu_op        = op;
        bus.rs_to_alu_rs1       = a;
        bus.rs_to_alu_rs2       = b;
        bus.rs_to_alu_imm       = imm;
        bus.rs_to_alu_PC        = pc;
        bus.rs_to_alu_rob_index = rob;
    endtask

    task automatic idle();
        bus.rs_to_alu_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cdb_grant_in = 1'b1;
        issue(6'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd3);
        tick();
        tick();
        n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.alu_full); end
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.alu_to_rs_ready); end
        n_checks++; if (bus.alu_to_rs_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.alu_to_rs_result); end
        n_checks++; if (bus.alu_to_rs_rob_index !== 4'h0) begin n_fail++; $display("FAIL reset_rob: got %h want 0", bus.alu_to_rs_rob_index); end
        n_checks++; if (bus.alu_to_rob_jump !== 1'b0) begin n_fail++; $display("FAIL reset_jump: got %b want 0", bus.alu_to_rob_jump); end
        n_checks++; if (bus.alu_to_rob_target !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", bus.alu_to_rob_target); end
        rst = 1'b0;
        idle();
        bus.cdb_grant_in = 1'b0;
        tick();
    endtask

    task automatic test_add();
        bus.cdb_grant_in = 1'b1;
        issue(6'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h10, 4'd3);
        tick();
        idle();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", bus.alu_to_rs_ready); end
        n_checks++; if (bus.alu_to_rs_result !== 32'h80000000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", bus.alu_to_rs_result); end
        n_checks++; if (bus.alu_to_rs_rob_index !== 4'd3) begin n_fail++; $display("FAIL add_rob: got %0d want 3", bus.alu_to_rs_rob_index); end
        n_checks++; if (bus.alu_to_rob_jump !== 1'b0) begin n_fail++; $display("FAIL add_jump: got %b want 0", bus.alu_to_rob_jump); end
        n_checks++; if (bus.alu_to_rob_target !== 32'h14) begin n_fail++; $display("FAIL add_target: got %h want 14", bus.alu_to_rob_target); end
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL add_popped: got ready %b want 0", bus.alu_to_rs_ready); end
        bus.cdb_grant_in = 1'b0;
    endtask

    task automatic test_alu_ops();
        vec_t v[$];
        logic [3:0] rob;
        v.push_back('{6'd1,  32'h5,        32'h7,        32'h0,        32'h1000, 32'hFFFFFFFE, 32'h1004, 1'b0});
        v.push_back('{6'd2,  32'h1,        32'h21,       32'h0,        32'h1000, 32'h2,        32'h1004, 1'b0});
        v.push_back('{6'd4,  32'h1,        32'hFFFFFFFF, 32'h0,        32'h1000, 32'h1,        32'h1004, 1'b0});
        v.push_back('{6'd3,  32'h1,        32'hFFFFFFFF, 32'h0,        32'h1000, 32'h0,        32'h1004, 1'b0});
        v.push_back('{6'd6,  32'h80000000, 32'd31,       32'h0,        32'h1000, 32'h1,        32'h1004, 1'b0});
        v.push_back('{6'd18, 32'h80000010, 32'h0,        32'h24,       32'h1000, 32'hF8000001, 32'h1004, 1'b0});
        v.push_back('{6'd13, 32'hFF00FF00, 32'h0,        32'hFFFFFFFF, 32'h1000, 32'h00FF00FF, 32'h1004, 1'b0});
        v.push_back('{6'd12, 32'h5,        32'h0,        32'hFFFFFFFF, 32'h1000, 32'h1,        32'h1004, 1'b0});
        v.push_back('{6'd19, 32'h0,        32'h0,        32'h12345000, 32'h1000, 32'h12345000, 32'h1004, 1'b0});
        v.push_back('{6'd20, 32'h0,        32'h0,        32'h2000,     32'h1000, 32'h3000,     32'h1004, 1'b0});
        v.push_back('{6'd21, 32'h0,        32'h0,        32'hFFFFFFF0, 32'h200,  32'h204,      32'h1F0,  1'b1});
        v.push_back('{6'd22, 32'h203,      32'h0,        32'h0,        32'h100,  32'h104,      32'h202,  1'b1});
        v.push_back('{6'd24, 32'h5,        32'h5,        32'h10,       32'h40,   32'h0,        32'h44,   1'b0});
        v.push_back('{6'd25, 32'hFFFFFFFF, 32'h1,        32'h8,        32'h80,   32'h0,        32'h88,   1'b1});
        v.push_back('{6'd28, 32'h1,        32'hFFFFFFFF, 32'h8,        32'h80,   32'h0,        32'h84,   1'b0});
        v.push_back('{6'd40, 32'h3,        32'h4,        32'h8,        32'h80,   32'h0,        32'h84,   1'b0});
        v.push_back('{6'd9,  32'hF0F0,     32'h0FF0,     32'h0,        32'h1000, 32'h00F0,     32'h1004, 1'b0});
        bus.cdb_grant_in = 1'b1;
        for (int i = 0; i < v.size(); i++) begin
            rob = 4'((i % 15) + 1);
            issue(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].pc, rob);
            tick();
            idle();
            n_checks++; if (bus.alu_to_rs_result !== v[i].res) begin n_fail++; $display("FAIL op%0d_result: got %h want %h", v[i].op, bus.alu_to_rs_result, v[i].res); end
            n_checks++; if (bus.alu_to_rob_jump !== v[i].jmp) begin n_fail++; $display("FAIL op%0d_jump: got %b want %b", v[i].op, bus.alu_to_rob_jump, v[i].jmp); end
            n_checks++; if (bus.alu_to_rob_target !== v[i].tgt) begin n_fail++; $display("FAIL op%0d_target: got %h want %h", v[i].op, bus.alu_to_rob_target, v[i].tgt); end
            n_checks++; if (bus.alu_to_rs_rob_index !== rob) begin n_fail++; $display("FAIL op%0d_rob: got %0d want %0d", v[i].op, bus.alu_to_rs_rob_index, rob); end
            tick();
        end
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL ops_drained: got ready %b want 0", bus.alu_to_rs_ready); end
        bus.cdb_grant_in = 1'b0;
    endtask

    task automatic test_full();
        int p0;
        p0 = proto_err;
        bus.cdb_grant_in = 1'b0;
        issue(6'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        tick();
        n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL full_one_entry: got %b want 0", bus.alu_full); end
        issue(6'd0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
        tick();
        n_checks++; if (bus.alu_full !== 1'b1) begin n_fail++; $display("FAIL full_two_entries: got %b want 1", bus.alu_full); end
        issue(6'd0, 32'd3, 32'd3, 32'd0, 32'd0, 4'd3);
        tick();
        idle();
        n_checks++; if (proto_err - p0 !== 1) begin n_fail++; $display("FAIL full_drop_flagged: got %0d protocol errors want 1", proto_err - p0); end
        n_checks++; if (bus.alu_to_rs_rob_index !== 4'd1) begin n_fail++; $display("FAIL full_head: got %0d want 1", bus.alu_to_rs_rob_index); end
        bus.cdb_grant_in = 1'b1;
        tick();
        n_checks++; if (bus.alu_to_rs_rob_index !== 4'd2) begin n_fail++; $display("FAIL full_second: got %0d want 2", bus.alu_to_rs_rob_index); end
        n_checks++; if (bus.alu_to_rs_result !== 32'd4) begin n_fail++; $display("FAIL full_second_result: got %h want 4", bus.alu_to_rs_result); end
        n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL full_after_pop: got %b want 0", bus.alu_full); end
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL full_drained: got ready %b want 0", bus.alu_to_rs_ready); end
        bus.cdb_grant_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.cdb_grant_in = 1'b0;
        issue(6'd0, 32'd4, 32'd0, 32'd0, 32'd0, 4'd4);
        tick();
        bus.cdb_grant_in = 1'b1;
        issue(6'd0, 32'd5, 32'd0, 32'd0, 32'd0, 4'd5);
        tick();
        idle();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.alu_to_rs_ready); end
        n_checks++; if (bus.alu_to_rs_rob_index !== 4'd5) begin n_fail++; $display("FAIL b2b_head: got %0d want 5", bus.alu_to_rs_rob_index); end
        n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", bus.alu_full); end
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got ready %b want 0", bus.alu_to_rs_ready); end
        for (int k = 1; k <= 5; k++) begin
            issue(6'd10, 32'(k * 16), 32'd0, 32'd1, 32'd0, 4'(k));
            tick();
            n_checks++; if (bus.alu_to_rs_rob_index !== 4'(k)) begin n_fail++; $display("FAIL wrap_rob%0d: got %0d want %0d", k, bus.alu_to_rs_rob_index, k); end
            n_checks++; if (bus.alu_to_rs_result !== 32'(k * 16 + 1)) begin n_fail++; $display("FAIL wrap_result%0d: got %h want %h", k, bus.alu_to_rs_result, 32'(k * 16 + 1)); end
        end
        idle();
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got ready %b want 0", bus.alu_to_rs_ready); end
        bus.cdb_grant_in = 1'b0;
    endtask

    task automatic test_clear();
        bus.cdb_grant_in = 1'b0;
        issue(6'd0, 32'd7, 32'd0, 32'd0, 32'd0, 4'd7);
        tick();
        issue(6'd0, 32'd8, 32'd0, 32'd0, 32'd0, 4'd8);
        tick();
        n_checks++; if (bus.alu_full !== 1'b1) begin n_fail++; $display("FAIL clr_prefull: got %b want 1", bus.alu_full); end
        clr = 1'b1;
        bus.cdb_grant_in = 1'b1;
        issue(6'd0, 32'd9, 32'd0, 32'd0, 32'd0, 4'd9);
        tick();
        clr = 1'b0;
        idle();
        bus.cdb_grant_in = 1'b0;
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b want 0", bus.alu_to_rs_ready); end
        n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL clr_full: got %b want 0", bus.alu_full); end
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL clr_no_push: got ready %b want 0", bus.alu_to_rs_ready); end
        issue(6'd0, 32'd10, 32'd0, 32'd0, 32'd0, 4'd10);
        tick();
        idle();
        rdy = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rdy = 1'b1;
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL clr_while_stalled: got ready %b want 0", bus.alu_to_rs_ready); end
    endtask

    task automatic test_hold();
        bus.cdb_grant_in = 1'b0;
        issue(6'd0, 32'd10, 32'd0, 32'd0, 32'd0, 4'd10);
        tick();
        rdy = 1'b0;
        bus.cdb_grant_in = 1'b1;
        issue(6'd0, 32'd11, 32'd0, 32'd0, 32'd0, 4'd11);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (bus.alu_to_rs_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 1", c, bus.alu_to_rs_ready); end
            n_checks++; if (bus.alu_to_rs_rob_index !== 4'd10) begin n_fail++; $display("FAIL hold_head%0d: got %0d want 10", c, bus.alu_to_rs_rob_index); end
            n_checks++; if (bus.alu_full !== 1'b0) begin n_fail++; $display("FAIL hold_full%0d: got %b want 0", c, bus.alu_full); end
        end
        idle();
        rdy = 1'b1;
        tick();
        n_checks++; if (bus.alu_to_rs_ready !== 1'b0) begin n_fail++; $display("FAIL hold_release: got ready %b want 0", bus.alu_to_rs_ready); end
        bus.cdb_grant_in = 1'b0;
    endtask

    initial begin
        bus.rs_to_alu_ready     = 1'b0;
        bus.rs_to_alu_op        = '0;
        bus.rs_to_alu_rs1       = '0;
        bus.rs_to_alu_rs2       = '0;
        bus.rs_to_alu_imm       = '0;
        bus.rs_to_alu_PC        = '0;
        bus.rs_to_alu_rob_index = '0;
        bus.cdb_grant_in        = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_full();
        test_back_to_back();
        test_clear();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
